// File: rtl/unroller_if.sv
// Beat-in / vector-out stream bundle for the unroller.
// slave is the unroller's view; master is the upstream/downstream environment.
interface unroller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 4
);
  logic [ROLL_NUM-1:0][DATA_WIDTH-1:0] data_in;
  logic                                data_in_valid;
  logic                                data_in_ready;
  logic [NUM-1:0][DATA_WIDTH-1:0]      data_out;
  logic                                data_out_valid;
  logic                                data_out_ready;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/unroller.sv
// Reassembles BEATS consecutive ROLL_NUM-element beats into one NUM-element vector.
// Two banks let the next vector fill while the finished one waits on backpressure.
module unroller_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_sel,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [1:0][DATA_WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      for (int b = 0; b < 2; b++)
        if (wr_en[b]) q[b] <= din;
    end
  end

  assign dout = q[rd_sel];
endmodule

module unroller #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 4
) (
  input  logic      clk,
  input  logic      rst,
  unroller_if.slave bus
);
  localparam int BEATS = NUM / ROLL_NUM;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NUM % ROLL_NUM != 0) begin : g_bad_cfg
    $error("unroller: NUM must be a multiple of ROLL_NUM");
  end

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

  bank_st_t              bank_st [2];
  logic [1:0]            full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [CW-1:0]         beat_cnt;
  logic                  in_fire;
  logic                  out_fire;
  logic                  last_beat;
  logic [BEATS-1:0]      beat_hit;
  logic [DATA_WIDTH-1:0] lane_q [NUM];

  always_comb begin
    full = '0;
    for (int b = 0; b < 2; b++) full[b] = (bank_st[b] == FULL);
  end

  // Ready and valid decode registered state only, so neither side sees a comb path.
  assign bus.data_in_ready  = !full[wr_bank];
  assign bus.data_out_valid = full[rd_bank];
  assign in_fire   = bus.data_in_valid && bus.data_in_ready;
  assign out_fire  = bus.data_out_valid && bus.data_out_ready;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) bank_st[b] <= EMPTY;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      // Fill and drain never hit the same bank: fill needs !FULL, drain needs FULL.
      for (int b = 0; b < 2; b++) begin
        if (out_fire && (rd_bank == b[0]))
          bank_st[b] <= EMPTY;
        else if (in_fire && (wr_bank == b[0]))
          bank_st[b] <= last_beat ? FULL : FILLING;
      end
      if (in_fire) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
        if (last_beat) wr_bank <= ~wr_bank;
      end
      if (out_fire) rd_bank <= ~rd_bank;
    end
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_hit
    assign beat_hit[k] = in_fire && (beat_cnt == CW'(k));
  end

  // Beat k lands in elements k*ROLL_NUM .. k*ROLL_NUM+ROLL_NUM-1.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    unroller_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_en  ({beat_hit[i / ROLL_NUM] & wr_bank, beat_hit[i / ROLL_NUM] & ~wr_bank}),
      .din    (bus.data_in[i % ROLL_NUM]),
      .rd_sel (rd_bank),
      .dout   (lane_q[i])
    );
  end

  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < NUM; i++) bus.data_out[i] = lane_q[i];
  end
endmodule

// File: tb/tb_unroller.sv
// Directed and randomised checks of unroller in 8/4, 4/4 and 12/3 configurations.
module tb_unroller;
  localparam int DW = 16;

  typedef logic [7:0][DW-1:0]  vec8_t;
  typedef logic [3:0][DW-1:0]  beat4_t;
  typedef logic [11:0][DW-1:0] vec12_t;
  typedef logic [2:0][DW-1:0]  beat3_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  unroller_if #(.DATA_WIDTH(DW), .NUM(8),  .ROLL_NUM(4)) ia ();
  unroller_if #(.DATA_WIDTH(DW), .NUM(4),  .ROLL_NUM(4)) ib ();
  unroller_if #(.DATA_WIDTH(DW), .NUM(12), .ROLL_NUM(3)) ic ();

  unroller #(.DATA_WIDTH(DW), .NUM(8),  .ROLL_NUM(4)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  unroller #(.DATA_WIDTH(DW), .NUM(4),  .ROLL_NUM(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  unroller #(.DATA_WIDTH(DW), .NUM(12), .ROLL_NUM(3)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic beat4_t mk4(input int base);
    beat4_t b;
    for (int i = 0; i < 4; i++) b[i] = DW'(base + i);
    return b;
  endfunction

  function automatic vec8_t mk8(input int base);
    vec8_t v;
    for (int i = 0; i < 8; i++) v[i] = DW'(base + i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.data_in = '0; ia.data_in_valid = 1'b0; ia.data_out_ready = 1'b1;
    ib.data_in = '0; ib.data_in_valid = 1'b0; ib.data_out_ready = 1'b1;
    ic.data_in = '0; ic.data_in_valid = 1'b0; ic.data_out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    total_cnt++;
    if (ia.data_in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ia.data_in_ready);
    else pass_cnt++;
    total_cnt++;
    if (ia.data_out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ia.data_out_valid);
    else pass_cnt++;
    total_cnt++;
    if (ia.data_out !== vec8_t'(0)) $display("FAIL reset_data: got %h want 0", ia.data_out);
    else pass_cnt++;
    step();
    rst = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    ia.data_in = mk4(1); ia.data_in_valid = 1'b1;
    total_cnt++;
    if (ia.data_in_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", ia.data_in_ready);
    else pass_cnt++;
    step();
    ia.data_in = mk4(5);
    total_cnt++;
    if (ia.data_out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", ia.data_out_valid);
    else pass_cnt++;
    step();
    ia.data_in_valid = 1'b0;
    total_cnt++;
    if (ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(1))
      $display("FAIL basic_vec: got v=%b %h want v=1 %h", ia.data_out_valid, ia.data_out, mk8(1));
    else pass_cnt++;
    step();
    total_cnt++;
    if (ia.data_out_valid !== 1'b0) $display("FAIL basic_one_cycle: got %b want 0", ia.data_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ia.data_out_ready = 1'b0;
    ia.data_in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ia.data_in = mk4(4 * k + 1);
      total_cnt++;
      if (ia.data_in_ready !== 1'b1) $display("FAIL bp_accept%0d: got %b want 1", k, ia.data_in_ready);
      else pass_cnt++;
      step();
    end
    ia.data_in = mk4(17);
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (ia.data_in_ready !== 1'b0 || ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(1))
        $display("FAIL bp_hold%0d: got r=%b v=%b %h want r=0 v=1 %h", c,
                 ia.data_in_ready, ia.data_out_valid, ia.data_out, mk8(1));
      else pass_cnt++;
      step();
    end
    ia.data_out_ready = 1'b1;
    total_cnt++;
    if (ia.data_in_ready !== 1'b0) $display("FAIL bp_no_comb_ready: got %b want 0", ia.data_in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(9) || ia.data_in_ready !== 1'b1)
      $display("FAIL bp_second: got v=%b r=%b %h want v=1 r=1 %h",
               ia.data_out_valid, ia.data_in_ready, ia.data_out, mk8(9));
    else pass_cnt++;
    step();
    ia.data_in = mk4(21);
    total_cnt++;
    if (ia.data_out_valid !== 1'b0) $display("FAIL bp_fifth_partial: got %b want 0", ia.data_out_valid);
    else pass_cnt++;
    step();
    ia.data_in_valid = 1'b0;
    total_cnt++;
    if (ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(17))
      $display("FAIL bp_third: got v=%b %h want v=1 %h", ia.data_out_valid, ia.data_out, mk8(17));
    else pass_cnt++;
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    ia.data_out_ready = 1'b0;
    ia.data_in_valid  = 1'b1;
    ia.data_in = mk4(100); step();
    ia.data_in = mk4(104); step();
    ia.data_in = mk4(200); step();
    ia.data_in = mk4(204);
    ia.data_out_ready = 1'b1;
    total_cnt++;
    if (ia.data_in_ready !== 1'b1 || ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(100))
      $display("FAIL simul_pre: got r=%b v=%b %h want r=1 v=1 %h",
               ia.data_in_ready, ia.data_out_valid, ia.data_out, mk8(100));
    else pass_cnt++;
    step();
    ia.data_in_valid = 1'b0;
    total_cnt++;
    if (ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(200) || ia.data_in_ready !== 1'b1)
      $display("FAIL simul_next: got v=%b r=%b %h want v=1 r=1 %h",
               ia.data_out_valid, ia.data_in_ready, ia.data_out, mk8(200));
    else pass_cnt++;
    step();
    total_cnt++;
    if (ia.data_out_valid !== 1'b0) $display("FAIL simul_drained: got %b want 0", ia.data_out_valid);
    else pass_cnt++;
  endtask

  task automatic test_random(input int nvec, input bit stall, input string name);
    vec8_t q[$];
    vec8_t cur, prev_d;
    logic  prev_stall = 1'b0;
    int bidx = 0, sent = 0, got = 0, errs = 0, holds = 0, bubbles = 0, cyc = 0;
    do_reset();
    for (int i = 0; i < 8; i++) cur[i] = DW'($urandom);
    while (got < nvec && cyc < 20000) begin
      if (prev_stall && (ia.data_out_valid !== 1'b1 || ia.data_out !== prev_d)) holds++;
      ia.data_out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      ia.data_in_valid  = (sent < nvec) && (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
      ia.data_in        = cur[bidx*4 +: 4];
      if (ia.data_out_valid && ia.data_out_ready) begin
        if (q.size() == 0 || q[0] !== ia.data_out) errs++;
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (ia.data_in_valid && !ia.data_in_ready && !stall) bubbles++;
      if (ia.data_in_valid && ia.data_in_ready) begin
        if (bidx == 1) begin
          q.push_back(cur);
          sent++;
          bidx = 0;
          for (int i = 0; i < 8; i++) cur[i] = DW'($urandom);
        end else bidx++;
      end
      prev_stall = ia.data_out_valid && !ia.data_out_ready;
      prev_d     = ia.data_out;
      step();
      cyc++;
    end
    idle_inputs();
    total_cnt++;
    if (got !== nvec) $display("FAIL %s_count: got %0d vectors want %0d", name, got, nvec);
    else pass_cnt++;
    total_cnt++;
    if (errs !== 0) $display("FAIL %s_data: got %0d wrong vectors want 0", name, errs);
    else pass_cnt++;
    total_cnt++;
    if (holds !== 0) $display("FAIL %s_hold: got %0d unstable stalls want 0", name, holds);
    else pass_cnt++;
    total_cnt++;
    if (bubbles !== 0) $display("FAIL %s_bubbles: got %0d want 0", name, bubbles);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ia.data_out_ready = 1'b0;
    ia.data_in_valid  = 1'b1;
    ia.data_in = mk4(1); step();
    ia.data_in = mk4(5); step();
    ia.data_in = {4{DW'(9)}}; step();
    ia.data_in_valid = 1'b0;
    total_cnt++;
    if (ia.data_out_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", ia.data_out_valid);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (ia.data_in_ready !== 1'b1 || ia.data_out_valid !== 1'b0 || ia.data_out !== vec8_t'(0))
      $display("FAIL rmid_async: got r=%b v=%b %h want r=1 v=0 0",
               ia.data_in_ready, ia.data_out_valid, ia.data_out);
    else pass_cnt++;
    step();
    rst = 1'b1;
    ia.data_out_ready = 1'b1;
    ia.data_in_valid  = 1'b1;
    ia.data_in = mk4(1); step();
    ia.data_in = mk4(5);
    total_cnt++;
    if (ia.data_out_valid !== 1'b0) $display("FAIL rmid_partial: got %b want 0", ia.data_out_valid);
    else pass_cnt++;
    step();
    ia.data_in_valid = 1'b0;
    total_cnt++;
    if (ia.data_out_valid !== 1'b1 || ia.data_out !== mk8(1))
      $display("FAIL rmid_vec: got v=%b %h want v=1 %h", ia.data_out_valid, ia.data_out, mk8(1));
    else pass_cnt++;
    step();
  endtask

  task automatic test_degenerate();
    vec12_t exp12;
    beat3_t b3;
    do_reset();
    ib.data_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ib.data_in = mk4(10 * k + 1);
      step();
      total_cnt++;
      if (ib.data_out_valid !== 1'b1 || ib.data_out !== mk4(10 * k + 1))
        $display("FAIL deg44_beat%0d: got v=%b %h want v=1 %h", k, ib.data_out_valid, ib.data_out, mk4(10 * k + 1));
      else pass_cnt++;
    end
    ib.data_in_valid = 1'b0;
    step();
    total_cnt++;
    if (ib.data_out_valid !== 1'b0) $display("FAIL deg44_drained: got %b want 0", ib.data_out_valid);
    else pass_cnt++;
    ic.data_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) b3[i] = DW'(3 * k + i + 1);
      ic.data_in = b3;
      total_cnt++;
      if (ic.data_out_valid !== 1'b0) $display("FAIL deg123_early%0d: got %b want 0", k, ic.data_out_valid);
      else pass_cnt++;
      step();
    end
    ic.data_in_valid = 1'b0;
    for (int i = 0; i < 12; i++) exp12[i] = DW'(i + 1);
    total_cnt++;
    if (ic.data_out_valid !== 1'b1 || ic.data_out !== exp12)
      $display("FAIL deg123_vec: got v=%b %h want v=1 %h", ic.data_out_valid, ic.data_out, exp12);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_random(100, 1'b0, "stream");
    test_reset_mid();
    test_degenerate();
    test_random(1000, 1'b1, "stall");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
